// File: rtl/inv_mix_columns_iter.sv
// rtl/inv_mix_columns_iter.sv - AES InvMixColumns, one column per cycle through a shared column core.
// Define INV_MIX_COLUMNS_PARALLEL_EN to transform all four columns in a single BUSY cycle.
module inv_mix_columns_iter #(
   parameter int NCOLS = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [0:127] in_state,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [0:127] out_state
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t       state, state_next;
   logic [0:127] work, work_next, work_xf, out_next;
   logic         accept_ok;
   logic         last_col;

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   // Column word packs row 0 in bits [31:24] down to row 3 in bits [7:0].
   function automatic logic [31:0] inv_col(input logic [31:0] w);
      logic [7:0] a [4];
      logic [7:0] x2 [4];
      logic [7:0] x4 [4];
      logic [7:0] x8 [4];
      logic [7:0] m9 [4];
      logic [7:0] mb [4];
      logic [7:0] md [4];
      logic [7:0] me [4];
      for (int r = 0; r < 4; r++) begin
         a[r]  = w[8*(3-r) +: 8];
         x2[r] = xtime(a[r]);
         x4[r] = xtime(x2[r]);
         x8[r] = xtime(x4[r]);
         m9[r] = x8[r] ^ a[r];
         mb[r] = x8[r] ^ x2[r] ^ a[r];
         md[r] = x8[r] ^ x4[r] ^ a[r];
         me[r] = x8[r] ^ x4[r] ^ x2[r];
      end
      return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
              m9[0] ^ me[1] ^ mb[2] ^ md[3],
              md[0] ^ m9[1] ^ me[2] ^ mb[3],
              mb[0] ^ md[1] ^ m9[2] ^ me[3]};
   endfunction

   function automatic logic [31:0] get_col(input logic [0:127] s, input int c);
      logic [31:0] w;
      for (int r = 0; r < 4; r++) w[8*(3-r) +: 8] = s[32*r + 8*c +: 8];
      return w;
   endfunction

   function automatic logic [0:127] put_col(input logic [0:127] s, input int c, input logic [31:0] w);
      logic [0:127] t;
      t = s;
      for (int r = 0; r < 4; r++) t[32*r + 8*c +: 8] = w[8*(3-r) +: 8];
      return t;
   endfunction

`ifdef INV_MIX_COLUMNS_PARALLEL_EN
   always_comb begin
      work_xf = work;
      for (int c = 0; c < NCOLS; c++) work_xf = put_col(work_xf, c, inv_col(get_col(work, c)));
   end

   assign last_col = 1'b1;
`else
   logic [1:0] col;

   always_comb begin
      work_xf = put_col(work, int'(col), inv_col(get_col(work, int'(col))));
   end

   assign last_col = (col == 2'(NCOLS - 1));

   // Natural 2-bit wrap brings col back to 0 as BUSY is left.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col <= 2'd0;
      end else if (accept_ok && in_valid) begin
         col <= 2'd0;
      end else if (state == BUSY) begin
         col <= col + 2'd1;
      end
   end
`endif

   always_comb begin
      state_next = state;
      work_next  = work;
      out_next   = out_state;
      accept_ok  = 1'b0;
      out_valid  = 1'b0;
      case (state)
         IDLE: accept_ok = 1'b1;
         BUSY: begin
            work_next = work_xf;
            if (last_col) begin
               state_next = DONE;
               out_next   = work_xf;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               accept_ok  = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
      if (accept_ok && in_valid) begin
         work_next  = in_state;
         state_next = BUSY;
      end
   end

   assign in_ready = accept_ok & rst_n;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         work      <= '0;
         out_state <= '0;
      end else begin
         state     <= state_next;
         work      <= work_next;
         out_state <= out_next;
      end
   end

endmodule

// File: tb/tb_inv_mix_columns_iter.sv
// tb/tb_inv_mix_columns_iter.sv - Self-checking bench for inv_mix_columns_iter against a GF(2^8) matrix model.
module tb_inv_mix_columns_iter;

`ifdef INV_MIX_COLUMNS_PARALLEL_EN
   localparam int LAT = 1;
`else
   localparam int LAT = 4;
`endif
   localparam logic [31:0] INV_COEF = 32'h0e0b0d09;
   localparam logic [31:0] FWD_COEF = 32'h02030101;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [0:127] in_state = '0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [0:127] out_state;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   inv_mix_columns_iter #(.NCOLS(4)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_state(in_state),
      .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state)
   );

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [14:0] p;
      p = '0;
      for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
      for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (15'h11b << (i - 8));
      return p[7:0];
   endfunction

   function automatic logic [31:0] mix_col(input logic [31:0] w, input logic [31:0] coef);
      logic [31:0] o;
      logic [7:0]  b;
      for (int r = 0; r < 4; r++) begin
         b = 8'h00;
         for (int k = 0; k < 4; k++) b = b ^ gmul(coef[8*(3-((k-r)&3)) +: 8], w[8*(3-k) +: 8]);
         o[8*(3-r) +: 8] = b;
      end
      return o;
   endfunction

   function automatic logic [0:127] make_state(input logic [31:0] w0, input logic [31:0] w1,
                                               input logic [31:0] w2, input logic [31:0] w3);
      logic [31:0]  w [4];
      logic [0:127] s;
      w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++) s[32*r + 8*c +: 8] = w[c][8*(3-r) +: 8];
      return s;
   endfunction

   function automatic logic [0:127] mix_state(input logic [0:127] s, input logic [31:0] coef);
      logic [31:0]  w;
      logic [0:127] o;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) w[8*(3-r) +: 8] = s[32*r + 8*c +: 8];
         w = mix_col(w, coef);
         for (int r = 0; r < 4; r++) o[32*r + 8*c +: 8] = w[8*(3-r) +: 8];
      end
      return o;
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Cycle model: cycles of work left, whether a result is held, and what out_state must show.
   int           m_busy = 0;
   bit           m_have = 1'b0;
   logic [0:127] m_pend = '0;
   logic [0:127] m_out = '0;

   always @(negedge clk) begin
      logic exp_ready;
      if (!rst_n) begin
         chk1("rst_in_ready", in_ready, 1'b0);
         chk1("rst_out_valid", out_valid, 1'b0);
         chk("rst_out_state", out_state, 128'h0);
         m_busy = 0;
         m_have = 1'b0;
         m_out  = '0;
      end else begin
         exp_ready = (m_busy == 0) && (!m_have || out_ready);
         chk1("in_ready", in_ready, exp_ready);
         chk1("out_valid", out_valid, m_have);
         chk("out_state", out_state, m_out);
         if (m_busy > 0) begin
            m_busy--;
            if (m_busy == 0) begin
               m_have = 1'b1;
               m_out  = m_pend;
            end
         end else begin
            if (m_have && out_ready) m_have = 1'b0;
            if (in_valid && exp_ready) begin
               m_pend = mix_state(in_state, INV_COEF);
               m_busy = LAT;
            end
         end
      end
   end

   task automatic send(input logic [0:127] s);
      int n;
      in_valid = 1'b1;
      in_state = s;
      n = 0;
      forever begin
         @(negedge clk);
         if (in_ready) break;
         n++;
         if (n > 100) begin
            chk1("send_timeout", in_ready, 1'b1);
            break;
         end
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_valid(output int lat);
      int n;
      n = 0;
      forever begin
         @(negedge clk);
         n++;
         if (out_valid) break;
         if (n > 50) begin
            chk1("valid_timeout", out_valid, 1'b1);
            break;
         end
      end
      lat = n - 1;
   endtask

   task automatic run_one(input string name, input logic [0:127] s, input logic [0:127] exp);
      int lat;
      out_ready = 1'b1;
      send(s);
      wait_valid(lat);
      chk_int({name, "_latency"}, lat, LAT);
      chk(name, out_state, exp);
      @(posedge clk); #1;
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not complete by %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [0:127] s_a, s_b, r;
      int           lat;
      logic [31:0]  w;

      repeat (3) @(posedge clk);
      #1;
      chk1("reset_in_ready", in_ready, 1'b0);
      chk1("reset_out_valid", out_valid, 1'b0);
      chk("reset_out_state", out_state, 128'h0);
      rst_n = 1'b1;

      chk("pin_col0", 128'(mix_col(32'h8e4da1bc, INV_COEF)), 128'h db135345);
      chk("pin_col1", 128'(mix_col(32'h9fdc589d, INV_COEF)), 128'h f20a225c);
      chk("pin_col2", 128'(mix_col(32'h01010101, INV_COEF)), 128'h 01010101);
      chk("pin_col3", 128'(mix_col(32'hd5d5d7d6, INV_COEF)), 128'h d4d4d4d5);
      chk("pin_rt", 128'(mix_col(32'h4d7ebdf8, INV_COEF)), 128'h 2d26314c);
      for (int i = 0; i < 4; i++) begin
         w = $urandom;
         chk("pin_inverse", 128'(mix_col(mix_col(w, INV_COEF), FWD_COEF)), 128'(w));
      end

      run_one("tv_state", make_state(32'h8e4da1bc, 32'h9fdc589d, 32'h01010101, 32'hd5d5d7d6),
              make_state(32'hdb135345, 32'hf20a225c, 32'h01010101, 32'hd4d4d4d5));
      run_one("rt_state", make_state(32'h4d7ebdf8, 32'h4d7ebdf8, 32'h4d7ebdf8, 32'h4d7ebdf8),
              make_state(32'h2d26314c, 32'h2d26314c, 32'h2d26314c, 32'h2d26314c));
      run_one("c6_state", {16{8'hc6}}, {16{8'hc6}});
      run_one("zero_state", 128'h0, 128'h0);

      s_a = {$urandom, $urandom, $urandom, $urandom};
      s_b = {$urandom, $urandom, $urandom, $urandom};
      out_ready = 1'b0;
      send(s_a);
      wait_valid(lat);
      chk_int("bp_latency", lat, LAT);
      r = mix_state(s_a, INV_COEF);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("bp_hold_state", out_state, r);
         chk1("bp_hold_in_ready", in_ready, 1'b0);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_state  = s_b;
      @(negedge clk);
      chk1("b2b_in_ready", in_ready, 1'b1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      wait_valid(lat);
      chk_int("b2b_latency", lat, LAT);
      chk("b2b_state", out_state, mix_state(s_b, INV_COEF));
      @(posedge clk); #1;

      s_a = {$urandom, $urandom, $urandom, $urandom};
      s_b = ~s_a;
      send(s_a);
      in_valid = 1'b1;
      in_state = s_b;
      repeat ((LAT > 1) ? 2 : 1) begin
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      wait_valid(lat);
      chk("busy_ignore_state", out_state, mix_state(s_a, INV_COEF));
      @(posedge clk); #1;

      s_a = {$urandom, $urandom, $urandom, $urandom};
      send(s_a);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk1("abort_out_valid", out_valid, 1'b0);
      chk("abort_out_state", out_state, 128'h0);
      chk1("abort_in_ready", in_ready, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      s_b = {$urandom, $urandom, $urandom, $urandom};
      run_one("post_abort_state", s_b, mix_state(s_b, INV_COEF));

      for (int i = 0; i < 400; i++) begin
         in_valid  = 1'($urandom_range(0, 1));
         in_state  = {$urandom, $urandom, $urandom, $urandom};
         out_ready = ($urandom_range(0, 3) != 0);
         @(posedge clk); #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (10) @(posedge clk);
      #1;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
